// File: rtl/cp_pkg.sv
// Shared types and opcode constants for the coprocessor issue interface.
package cp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cp_state_t;

  localparam logic [4:0] CP_MUL  = 5'b00000;
  localparam logic [4:0] CP_MULH = 5'b00001;
  localparam logic [4:0] CP_DIVU = 5'b00010;
  localparam logic [4:0] CP_REMU = 5'b00011;

  localparam logic [5:0] COPROC_OPCODE_NOP = 6'b111111;

  // Only the four arithmetic codes are implemented; everything else is illegal.
  function automatic logic cp_is_legal(input logic [4:0] op);
    return (op == CP_MUL) || (op == CP_MULH) || (op == CP_DIVU) || (op == CP_REMU);
  endfunction

endpackage

// File: rtl/cp_iter_datapath.sv
// One-step-per-cycle shift/add multiplier and restoring divider sharing one
// {hi, lo} register pair: hi = product high / remainder, lo = product low / quotient.
module cp_iter_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi_next,
  output logic [WIDTH-1:0] o_lo_next
);

  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opb;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH:0]   w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  always_comb begin
    // r_hi[WIDTH] stays zero during a multiply, so the add cannot overflow WIDTH+1 bits.
    w_sum   = r_hi + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_shift = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, r_opb};
    w_ge    = ~w_diff[WIDTH];
    if (i_div) begin
      w_hi_next = w_ge ? w_diff : w_shift;
      w_lo_next = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_next = {1'b0, w_sum[WIDTH:1]};
      w_lo_next = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_hi_next = w_hi_next[WIDTH-1:0];
  assign o_lo_next = w_lo_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_opb <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_opb <= i_b;
    end else if (i_step) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
    end
  end

endmodule

// File: rtl/coprocessor_unit.sv
// Coprocessor responder: accepts MUL/MULH/DIVU/REMU issues, iterates WIDTH
// cycles and returns the result with a one-cycle done pulse.
module coprocessor_unit
  import cp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cp_enable,
  input  logic             cp_mem_src,
  input  logic [5:0]       cp_opcode,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] mem_data,
  output logic             cp_busy,
  output logic             cp_done,
  output logic [WIDTH-1:0] cp_result,
  output logic             cp_error
);

  cp_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;

  logic             w_accept;
  logic             w_step;
  logic             w_legal;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_unused_opcode_msb;

  assign w_accept            = cp_enable && (r_state != RUN);
  assign w_step              = (r_state == RUN);
  assign w_b                 = cp_mem_src ? mem_data : operand_b;
  assign w_legal             = cp_is_legal(cp_opcode[4:0]);
  assign w_b_zero            = (w_b == '0);
  assign w_unused_opcode_msb = cp_opcode[5];

  // Stall covers the issue cycle as well as every iteration cycle.
  assign cp_busy = w_step || w_accept;

  cp_iter_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .i_step    (w_step),
    .i_div     (r_op[1]),
    .i_a       (operand_a),
    .i_b       (w_b),
    .o_hi_next (w_hi_next),
    .o_lo_next (w_lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_op      <= '0;
      cp_done   <= 1'b0;
      cp_result <= '0;
      cp_error  <= 1'b0;
    end else begin
      cp_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Odd codes (MULH, REMU) take the hi half; even codes take lo.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state   <= DONE;
            cp_done   <= 1'b1;
            cp_result <= r_op[0] ? w_hi_next : w_lo_next;
            cp_error  <= 1'b0;
          end
        end
        default: begin
          if (w_accept) begin
            r_op  <= cp_opcode[1:0];
            r_cnt <= '0;
            if (!w_legal) begin
              r_state   <= DONE;
              cp_done   <= 1'b1;
              cp_result <= '0;
              cp_error  <= 1'b1;
            end else if (cp_opcode[1] && w_b_zero) begin
              r_state   <= DONE;
              cp_done   <= 1'b1;
              cp_result <= cp_opcode[0] ? operand_a : '1;
              cp_error  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/coprocessor_unit.md
Name: coprocessor_unit

Overview:
- Responder for the coprocessor issue interface driven by the control unit: accepts an instruction when cp_enable is asserted (opcodes 1xxxxx), executes it over multiple cycles, and returns the result with a done pulse.
- Drives a combinational busy/stall output that top-level logic ORs into the PC-hold path. Results go to the register writeback mux.
- Operations: iterative unsigned multiply (low/high word) and unsigned divide (quotient/remainder).

Parameters:
- WIDTH, 32, operand and result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cp_enable  in  1  issue strobe from the control unit
- cp_mem_src  in  1  operand B source: 1 = mem_data, 0 = operand_b
- cp_opcode  in  6  full instruction opcode; bits [4:0] select the operation
- operand_a  in  WIDTH  register operand A
- operand_b  in  WIDTH  register operand B
- mem_data  in  WIDTH  memory read data, alternate operand B
- cp_busy  out  1  stall request (combinational)
- cp_done  out  1  one-cycle pulse; cp_result and cp_error are valid
- cp_result  out  WIDTH  result word, held until the next accept
- cp_error  out  1  divide-by-zero or illegal opcode; valid with cp_done, held with the result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state = IDLE; cp_done = 0; cp_result = 0; cp_error = 0; counter = 0; internal operand and accumulator registers = 0.
- Operation encoding, cp_opcode[4:0]:
  - 00000 MUL: low WIDTH bits of A*B.
  - 00001 MULH: high WIDTH bits of the unsigned 2*WIDTH-bit product.
  - 00010 DIVU: A/B, unsigned.
  - 00011 REMU: A%B, unsigned.
  - Any other code, including opcode 111111: illegal.
- Operand latch: on accept, latch A = operand_a and B = (cp_mem_src ? mem_data : operand_b).
- States: IDLE, RUN, DONE.
- Accept rule: an accept occurs when cp_enable = 1 at a clock edge while state is IDLE or DONE. cp_enable is ignored in RUN.
- Accept of a legal MUL/MULH, or a legal DIVU/REMU with B != 0: go to RUN, counter = 0.
- Accept of DIVU/REMU with B == 0: go directly to DONE.
  - DIVU: cp_result = all ones.
  - REMU: cp_result = A.
  - cp_error = 1.
- Accept of an illegal opcode: go directly to DONE with cp_result = 0 and cp_error = 1.
- RUN: one iteration per cycle, exactly WIDTH cycles. When counter == WIDTH-1, load cp_result, set cp_error = 0, go to DONE.
  - Multiply: shift-add into a 2*WIDTH-bit accumulator.
  - Divide: restoring division with a WIDTH+1-bit partial remainder; no early termination.
- DONE: cp_done = 1 for exactly one cycle.
  - With no accept in that cycle: go to IDLE.
  - With an accept in that cycle: back-to-back; follow the accept rules.
- cp_result and cp_error change only on the DONE entry edge or on reset.
- cp_busy = (state == RUN) OR (cp_enable AND state in {IDLE, DONE}). The stall therefore covers the issue cycle and every RUN cycle. cp_busy = 0 in the DONE cycle unless a new issue is present.
- Latency, legal nonzero op: accept at the end of cycle C0; RUN covers C1..C_WIDTH; cp_done is high in C_{WIDTH+1}.
- Latency, error case: cp_done is high in C1.
- Width rule: all arithmetic is unsigned. The multiply accumulator is 2*WIDTH bits, so no overflow is lost.
- Reset mid-operation: the operation is aborted; all outputs return to reset values on the next edge; no cp_done pulse.

Decomposition:
- Shared package cp_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - operation code constants CP_MUL = 5'b00000, CP_MULH = 5'b00001, CP_DIVU = 5'b00010, CP_REMU = 5'b00011;
  - COPROC_OPCODE_NOP = 6'b111111.
- One natural sub-module: cp_iter_datapath, the shared shift register and accumulator performing one multiply or divide step per cycle under a mode select. The FSM and counter stay in coprocessor_unit.

Test Plan:
- MUL 7*6, cp_mem_src = 0 -> cp_busy high for cycles C0..C32; cp_done in C33; cp_result = 42; cp_error = 0.
- MULH and MUL with 0xFFFFFFFF*0xFFFFFFFF -> MULH result = 0xFFFFFFFE; MUL result = 0x00000001.
- DIVU and REMU 100/7, with B taken from mem_data = 7 (cp_mem_src = 1) and operand_b = 0 -> DIVU result = 14; REMU result = 2; cp_error = 0.
- DIVU 5/0 -> cp_done in C1; result = 0xFFFFFFFF; cp_error = 1. REMU 5/0 -> result = 5; cp_error = 1. Illegal code 5'b00111 -> result = 0; cp_error = 1.
- cp_enable pulsed mid-RUN -> ignored; the original result is unchanged. A new issue in the DONE cycle -> accepted; its cp_done arrives 33 cycles later; the first result is held until that pulse.
- rst asserted at RUN cycle 10 -> next cycle IDLE; cp_result = 0; no cp_done. A following MUL 3*3 -> 9.
